skid_fifo_sync: RTL

//  Parametrised-depth successor to the 2-entry skid buffer, for valid/ready channels (AXI/AXI-Lite/AXI-Stream cores).

---
 rtl/skid_fifo_sync.sv | 96 +++++++++
 1 files changed

// File: rtl/skid_fifo_sync.sv
// skid_fifo_sync: DEPTH-entry first-word-fall-through valid/ready FIFO with occupancy count and almost-full flag.
// Define SKID_FIFO_FLUSH_EN to add a synchronous flush input that empties the queue in one cycle.
module skid_fifo_sync #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
`ifdef SKID_FIFO_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("skid_fifo_sync: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_afull_chk
    $error("skid_fifo_sync: AFULL_LEVEL must lie in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         used;
  logic                  past_reset_q;
  logic                  empty, full, rx, tx, wr_en;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready  = !full && !past_reset_q;
  assign out_valid = !empty;
  assign rx        = in_valid && in_ready;
  assign tx        = out_valid && out_ready;

  assign used        = wr_ptr_q - rd_ptr_q;
  assign count       = CW'(used);
  assign almost_full = (32'(used) >= AFULL_LEVEL);
  assign out_data    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    if (rx) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      wr_en    = 1'b1;
    end
    if (tx) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
`ifdef SKID_FIFO_FLUSH_EN
    // Flush drops a same-cycle incoming beat; a same-cycle outgoing beat has already completed.
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      wr_en    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    past_reset_q <= !reset_n;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule
